// File: rtl/sdram_arbiter.sv
// Round-robin arbiter that connects the processing cores to the single SDRAMBus master port.
// One access is in flight at a time. Operation, address and data are latched at grant.
module sdram_arbiter #(
    parameter int N_CLIENTS = 5,
    parameter int ADDR_W    = 23,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 4096,
    localparam int ID_W     = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_CLIENTS-1:0]        req_read,
    input  logic [N_CLIENTS-1:0]        req_write,
    input  logic [N_CLIENTS*ADDR_W-1:0] req_addr,
    input  logic [N_CLIENTS*DATA_W-1:0] req_writedata,
    output logic [DATA_W-1:0]           req_readdata,
    output logic [N_CLIENTS-1:0]        req_finished,
    output logic                        sdram_read,
    output logic                        sdram_write,
    output logic [ADDR_W-1:0]           sdram_addr,
    output logic [DATA_W-1:0]           sdram_writedata,
    input  logic [DATA_W-1:0]           sdram_readdata,
    input  logic                        sdram_finished,
    output logic                        busy,
    output logic [ID_W-1:0]             grant_id,
    output logic                        err_timeout
);

    // state   | meaning
    // IDLE    | no access in flight; pick next requester from rr_ptr
    // GRANT   | strobe held to SDRAMBus until finished or watchdog expiry
    // RELEASE | one dead cycle so the served client can drop its request
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic                sdram_read_q, sdram_read_d;
    logic                sdram_write_q, sdram_write_d;
    logic [ADDR_W-1:0]   sdram_addr_q, sdram_addr_d;
    logic [DATA_W-1:0]   sdram_writedata_q, sdram_writedata_d;
    logic                err_timeout_q, err_timeout_d;
    logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;

    logic [N_CLIENTS-1:0] req_any;
    logic [ADDR_W-1:0]    addr_arr [N_CLIENTS];
    logic [DATA_W-1:0]    data_arr [N_CLIENTS];
    logic                 pick_found;
    logic [ID_W-1:0]      pick_idx;
    logic                 grant_done;

    assign req_any = req_read | req_write;

    always_comb begin
        for (int i = 0; i < N_CLIENTS; i++) begin
            addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
            data_arr[i] = req_writedata[i*DATA_W +: DATA_W];
        end
    end

    // First requester at or after rr_ptr, wrapping past the last client.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            if (!pick_found && req_any[(int'(rr_ptr_q) + k) % N_CLIENTS]) begin
                pick_found = 1'b1;
                pick_idx   = ID_W'((int'(rr_ptr_q) + k) % N_CLIENTS);
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        rr_ptr_d          = rr_ptr_q;
        grant_id_d        = grant_id_q;
        sdram_read_d      = sdram_read_q;
        sdram_write_d     = sdram_write_q;
        sdram_addr_d      = sdram_addr_q;
        sdram_writedata_d = sdram_writedata_q;
        err_timeout_d     = err_timeout_q;
        wd_cnt_d          = wd_cnt_q;
        grant_done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_id_d        = pick_idx;
                    sdram_write_d     = req_write[pick_idx];
                    sdram_read_d      = ~req_write[pick_idx];
                    sdram_addr_d      = addr_arr[pick_idx];
                    sdram_writedata_d = data_arr[pick_idx];
                    wd_cnt_d          = WD_LOAD;
                    state_d           = GRANT;
                end
            end
            GRANT: begin
                if (sdram_finished) begin
                    grant_done = 1'b1;
                end else if (TIMEOUT > 0 && wd_cnt_q == '0) begin
                    grant_done    = 1'b1;
                    err_timeout_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q - 1'b1;
                end
                if (grant_done) begin
                    sdram_read_d  = 1'b0;
                    sdram_write_d = 1'b0;
                    rr_ptr_d      = (grant_id_q == ID_W'(N_CLIENTS - 1)) ? '0 : grant_id_q + 1'b1;
                    state_d       = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q           <= IDLE;
            rr_ptr_q          <= '0;
            grant_id_q        <= '0;
            sdram_read_q      <= 1'b0;
            sdram_write_q     <= 1'b0;
            sdram_addr_q      <= '0;
            sdram_writedata_q <= '0;
            err_timeout_q     <= 1'b0;
            wd_cnt_q          <= '0;
        end else begin
            state_q           <= state_d;
            rr_ptr_q          <= rr_ptr_d;
            grant_id_q        <= grant_id_d;
            sdram_read_q      <= sdram_read_d;
            sdram_write_q     <= sdram_write_d;
            sdram_addr_q      <= sdram_addr_d;
            sdram_writedata_q <= sdram_writedata_d;
            err_timeout_q     <= err_timeout_d;
            wd_cnt_q          <= wd_cnt_d;
        end
    end

    // Completion goes only to the granted client, and only while a grant is live.
    always_comb begin
        req_finished = '0;
        if (state_q == GRANT && sdram_finished) begin
            req_finished[grant_id_q] = 1'b1;
        end
    end

    assign req_readdata    = sdram_readdata;
    assign sdram_read      = sdram_read_q;
    assign sdram_write     = sdram_write_q;
    assign sdram_addr      = sdram_addr_q;
    assign sdram_writedata = sdram_writedata_q;
    assign busy            = (state_q != IDLE);
    assign grant_id        = grant_id_q;
    assign err_timeout     = err_timeout_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios plus random transactions against a
// transaction-level round-robin model.
module tb_sdram_arbiter;

    localparam int N  = 5;
    localparam int AW = 23;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              clk;
    logic              i_rst;
    logic [N-1:0]      req_read;
    logic [N-1:0]      req_write;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_writedata;
    logic [DW-1:0]     req_readdata;
    logic [N-1:0]      req_finished;
    logic              sdram_read;
    logic              sdram_write;
    logic [AW-1:0]     sdram_addr;
    logic [DW-1:0]     sdram_writedata;
    logic [DW-1:0]     sdram_readdata;
    logic              sdram_finished;
    logic              busy;
    logic [2:0]        grant_id;
    logic              err_timeout;

    sdram_arbiter #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .req_read       (req_read),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_writedata  (req_writedata),
        .req_readdata   (req_readdata),
        .req_finished   (req_finished),
        .sdram_read     (sdram_read),
        .sdram_write    (sdram_write),
        .sdram_addr     (sdram_addr),
        .sdram_writedata(sdram_writedata),
        .sdram_readdata (sdram_readdata),
        .sdram_finished (sdram_finished),
        .busy           (busy),
        .grant_id       (grant_id),
        .err_timeout    (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: next round-robin start and the sticky watchdog flag.
    int          rr_m  = 0;
    logic        err_m = 1'b0;
    logic [AW-1:0] a_m [N];
    logic [DW-1:0] d_m [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_bus();
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]      = a_m[i];
            req_writedata[i*DW +: DW] = d_m[i];
        end
    endtask

    task automatic randomize_bus();
        for (int i = 0; i < N; i++) begin
            a_m[i] = AW'($urandom);
            d_m[i] = $urandom;
        end
        drive_bus();
    endtask

    // One full transaction starting from an IDLE cycle. lat < 0 means SDRAM never answers.
    task automatic run_txn(input logic [N-1:0] rd, input logic [N-1:0] wr, input int lat,
                           input bit scramble, input bit drop, output int got_id);
        int            w;
        logic          exp_w;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [DW-1:0] rdata;
        @(negedge clk);
        req_read       = rd;
        req_write      = wr;
        sdram_finished = 1'b0;
        drive_bus();
        w     = rr_pick(rd | wr, rr_m);
        exp_w = wr[w];
        ea    = a_m[w];
        ed    = d_m[w];
        rdata = '0;
        got_id = -1;
        #1;
        check("idle_busy", busy, 0);
        check("idle_strobe", {sdram_read, sdram_write}, 0);
        for (int c = 0; c < TO; c++) begin
            @(negedge clk);
            if (scramble) begin
                randomize_bus();
                req_read  = N'($urandom);
                req_write = N'($urandom);
            end
            if (c == lat) begin
                rdata          = $urandom;
                sdram_readdata = rdata;
                sdram_finished = 1'b1;
            end
            #1;
            if (c == 0) got_id = int'(grant_id);
            check("grant_id", grant_id, w);
            check("grant_busy", busy, 1);
            check("sdram_read", sdram_read, !exp_w);
            check("sdram_write", sdram_write, exp_w);
            check("sdram_addr", sdram_addr, ea);
            check("sdram_wdata", sdram_writedata, ed);
            check("req_finished", req_finished, (c == lat) ? (5'b00001 << w) : 5'b00000);
            if (c == lat) begin
                check("req_readdata", req_readdata, rdata);
                break;
            end
        end
        rr_m = (w + 1) % N;
        if (lat < 0) err_m = 1'b1;
        @(negedge clk);
        sdram_finished = scramble ? 1'($urandom) : 1'b0;
        if (drop) begin
            req_read[w]  = 1'b0;
            req_write[w] = 1'b0;
        end
        #1;
        check("rel_strobe", {sdram_read, sdram_write}, 0);
        check("rel_busy", busy, 1);
        check("rel_finished", req_finished, 0);
        check("err_timeout", err_timeout, err_m);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int got;
        logic [N-1:0] rd, wr;
        int lat;

        i_rst          = 1'b1;
        req_read       = '0;
        req_write      = '0;
        sdram_finished = 1'b0;
        sdram_readdata = '0;
        for (int i = 0; i < N; i++) begin
            a_m[i] = '0;
            d_m[i] = '0;
        end
        drive_bus();
        repeat (2) @(negedge clk);
        #1;
        check("rst_strobe", {sdram_read, sdram_write}, 0);
        check("rst_addr", sdram_addr, 0);
        check("rst_wdata", sdram_writedata, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_err", err_timeout, 0);
        check("rst_fin", req_finished, 0);
        i_rst = 1'b0;

        // Single read from client 4, SDRAM answers 5 cycles after the strobe.
        a_m[4] = 23'h000100;
        run_txn(5'b10000, 5'b00000, 5, 1'b0, 1'b1, got);
        check("t1_client", got, 4);

        // Contention among clients 1, 3 and 4 starting from rr_ptr 0.
        run_txn(5'b11010, 5'b00000, 1, 1'b0, 1'b1, got);
        check("t2_first", got, 1);
        run_txn(5'b11000, 5'b00000, 0, 1'b0, 1'b1, got);
        check("t2_second", got, 3);
        run_txn(5'b10000, 5'b00000, 2, 1'b0, 1'b1, got);
        check("t2_third", got, 4);

        // Everyone requesting continuously: strict rotation.
        for (int i = 0; i < 10; i++) begin
            run_txn(5'b11111, 5'b00000, i % 3, 1'b0, 1'b0, got);
            check("t3_rotation", got, i % N);
        end

        // Read and write both asserted on client 2 means a write.
        a_m[2] = 23'h1ABCDE;
        d_m[2] = 32'hDEADBEEF;
        run_txn(5'b00100, 5'b00100, 2, 1'b0, 1'b1, got);
        check("t4_client", got, 2);

        // Watchdog expiry, then the following client is served.
        run_txn(5'b11111, 5'b00000, -1, 1'b0, 1'b0, got);
        check("t5_err_set", err_timeout, 1);
        run_txn(5'b11111, 5'b00000, 0, 1'b0, 1'b1, lat);
        check("t5_next_client", lat, (got + 1) % N);

        // Reset in the middle of a grant, then a stray finished while idle.
        @(negedge clk);
        req_read = 5'b01000;
        req_write = '0;
        sdram_finished = 1'b0;
        @(negedge clk);
        #1;
        check("t6_pre_strobe", sdram_read, 1);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        req_read = '0;
        sdram_finished = 1'b1;
        #1;
        check("t6_strobe", {sdram_read, sdram_write}, 0);
        check("t6_busy", busy, 0);
        check("t6_fin", req_finished, 0);
        check("t6_err", err_timeout, 0);
        @(negedge clk);
        sdram_finished = 1'b0;
        #1;
        check("t6_stray_busy", busy, 0);
        rr_m  = 0;
        err_m = 1'b0;
        run_txn(5'b11111, 5'b00000, 1, 1'b0, 1'b1, got);
        check("t6_rr_reset", got, 0);

        // Random traffic with scrambled client inputs during grants.
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 5) == 0) begin
                @(negedge clk);
                req_read       = '0;
                req_write      = '0;
                sdram_finished = 1'($urandom);
                #1;
                check("gap_busy", busy, 0);
                check("gap_fin", req_finished, 0);
            end else begin
                rd = N'($urandom);
                wr = N'($urandom);
                if ((rd | wr) == '0) rd[$urandom_range(0, N-1)] = 1'b1;
                lat = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 6));
                randomize_bus();
                run_txn(rd, wr, lat, 1'b1, 1'($urandom), got);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
